// File: rtl/instr_fetch_queue.sv
// instr_fetch_queue: fetch stage that sits directly after the program counter.
// It owns the fetch address and issues one word request at a time to
// instruction memory. Returned words are queued together with their PC, and
// decode drains the queue through a valid/ready handshake. A redirect flushes
// the queue and any word still in flight.
//
// Optional feature: define IFQ_PERF_EN to add the perf_fetched/perf_flushed
// counters and their ports.
//
// Ports:
//   clk, rst               clock (rising edge), asynchronous active-high reset
//   redirect, redirect_pc  taken branch/jump and its target (bits [1:0] ignored)
//   imem_req, imem_addr    single-cycle request strobe and word address
//   imem_rvalid, imem_rdata memory response
//   if_valid, if_instr, if_pc  queue head toward decode
//   id_ready               decode accepts the head
//   perf_fetched           (IFQ_PERF_EN) count of words pushed into the queue
//   perf_flushed           (IFQ_PERF_EN) count of words discarded by redirects
module instr_fetch_queue #(
   parameter int unsigned      WIDTH    = 32,
   parameter int unsigned      DEPTH    = 2,
   parameter logic [WIDTH-1:0] RESET_PC = '0
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             redirect,
   input  logic [WIDTH-1:0] redirect_pc,
   output logic             imem_req,
   output logic [WIDTH-1:0] imem_addr,
   input  logic             imem_rvalid,
   input  logic [WIDTH-1:0] imem_rdata,
   output logic             if_valid,
   output logic [WIDTH-1:0] if_instr,
   output logic [WIDTH-1:0] if_pc,
   input  logic             id_ready
`ifdef IFQ_PERF_EN
   ,
   output logic [31:0]      perf_fetched,
   output logic [31:0]      perf_flushed
`endif
);

   localparam int unsigned PW = $clog2(DEPTH);
   localparam int unsigned CW = $clog2(DEPTH) + 1;
   localparam logic [WIDTH-1:0] ALIGN_MASK = ~WIDTH'(3);

   typedef enum logic [1:0] {
      IDLE    = 2'd0,
      WAIT    = 2'd1,
      DISCARD = 2'd2
   } state_t;

   state_t           state, state_nxt;
   logic [WIDTH-1:0] fetch_pc;
   logic [WIDTH-1:0] pc_inc;
   logic [WIDTH-1:0] q_pc    [DEPTH];
   logic [WIDTH-1:0] q_instr [DEPTH];
   logic [PW-1:0]    rd_ptr, wr_ptr;
   logic [CW-1:0]    count, cnt_after_pop;
   logic             pop, space_idle, space_wait;
   logic             issue, push, flush;

   assign pc_inc   = fetch_pc + WIDTH'(4);
   assign if_valid = (count != '0);
   assign if_pc    = q_pc[rd_ptr];
   assign if_instr = q_instr[rd_ptr];
   assign pop      = if_valid && id_ready;

   // Space is judged after this cycle's pop so a drained slot can be refilled
   // immediately; a response arriving later always finds a free entry.
   assign cnt_after_pop = count - CW'(pop);
   assign space_idle    = cnt_after_pop < CW'(DEPTH);
   assign space_wait    = (cnt_after_pop + CW'(1)) < CW'(DEPTH);

   // State register
   always_ff @(posedge clk or posedge rst) begin
      if (rst) state <= IDLE;
      else     state <= state_nxt;
   end

   // Next-state logic
   always_comb begin
      state_nxt = state;
      case (state)
         IDLE:    if (!redirect && space_idle) state_nxt = WAIT;
         WAIT: begin
            if (redirect)         state_nxt = imem_rvalid ? IDLE : DISCARD;
            else if (imem_rvalid) state_nxt = space_wait ? WAIT : IDLE;
         end
         DISCARD: if (imem_rvalid) state_nxt = IDLE;
         default: state_nxt = IDLE;
      endcase
   end

   // Output/control decode
   always_comb begin
      issue = 1'b0;
      push  = 1'b0;
      flush = 1'b0;
      case (state)
         IDLE: begin
            if (redirect)        flush = 1'b1;
            else if (space_idle) issue = 1'b1;
         end
         WAIT: begin
            if (redirect) flush = 1'b1;
            else if (imem_rvalid) begin
               push  = 1'b1;
               issue = space_wait;
            end
         end
         DISCARD: if (redirect) flush = 1'b1;
         default: ;
      endcase
   end

   // Request is gated by reset so nothing leaves the block while it is held.
   // In WAIT a new request targets the word after the one just returned.
   assign imem_req  = issue && !rst;
   assign imem_addr = imem_req ? ((state == WAIT) ? pc_inc : fetch_pc) : '0;

   // Fetch address
   always_ff @(posedge clk or posedge rst) begin
      if (rst)        fetch_pc <= RESET_PC & ALIGN_MASK;
      else if (flush) fetch_pc <= redirect_pc & ALIGN_MASK;
      else if (push)  fetch_pc <= pc_inc;
   end

   // Circular queue; flush takes priority over a same-cycle pop
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         rd_ptr <= '0;
         wr_ptr <= '0;
         count  <= '0;
         for (int i = 0; i < int'(DEPTH); i++) begin
            q_pc[i]    <= '0;
            q_instr[i] <= '0;
         end
      end else if (flush) begin
         rd_ptr <= '0;
         wr_ptr <= '0;
         count  <= '0;
      end else begin
         if (push) begin
            q_pc[wr_ptr]    <= fetch_pc;
            q_instr[wr_ptr] <= imem_rdata;
            wr_ptr          <= wr_ptr + PW'(1);
         end
         if (pop) rd_ptr <= rd_ptr + PW'(1);
         count <= count + CW'(push) - CW'(pop);
      end
   end

`ifdef IFQ_PERF_EN
   // Flushed words: everything queued plus the word in flight when in WAIT.
   // A word dropped later in DISCARD was already counted at the redirect.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         perf_fetched <= '0;
         perf_flushed <= '0;
      end else begin
         if (push)  perf_fetched <= perf_fetched + 32'(1);
         if (flush) perf_flushed <= perf_flushed + 32'(count) + 32'(state == WAIT);
      end
   end
`endif

endmodule

// File: tb/tb_instr_fetch_queue.sv
module tb_instr_fetch_queue;

   localparam int DEPTH_I = 2;

   logic        clk = 1'b0;
   logic        rst = 1'b0;
   logic        redirect = 1'b0;
   logic [31:0] redirect_pc = '0;
   logic        imem_req;
   logic [31:0] imem_addr;
   logic        imem_rvalid = 1'b0;
   logic [31:0] imem_rdata = '0;
   logic        if_valid;
   logic [31:0] if_instr;
   logic [31:0] if_pc;
   logic        id_ready = 1'b0;
`ifdef IFQ_PERF_EN
   logic [31:0] perf_fetched;
   logic [31:0] perf_flushed;
`endif

   instr_fetch_queue dut (
      .clk         (clk),
      .rst         (rst),
      .redirect    (redirect),
      .redirect_pc (redirect_pc),
      .imem_req    (imem_req),
      .imem_addr   (imem_addr),
      .imem_rvalid (imem_rvalid),
      .imem_rdata  (imem_rdata),
      .if_valid    (if_valid),
      .if_instr    (if_instr),
      .if_pc       (if_pc),
      .id_ready    (id_ready)
`ifdef IFQ_PERF_EN
      ,
      .perf_fetched(perf_fetched),
      .perf_flushed(perf_flushed)
`endif
   );

   always #5 clk = ~clk;

   int total = 0;
   int bad   = 0;
   int cyc   = 0;

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      total++;
      if (act !== exp) begin
         bad++;
         $display("FAIL %s: got %h expected %h", name, act, exp);
      end
   endtask

   task automatic chk1(input string name, input logic act, input logic exp);
      total++;
      if (act !== exp) begin
         bad++;
         $display("FAIL %s: got %b expected %b", name, act, exp);
      end
   endtask

   function automatic logic [31:0] mem_word(input logic [31:0] a);
      return a ^ 32'h1357_9BDF;
   endfunction

   // Instruction memory: fixed latency per request, any number pending
   typedef struct {
      logic [31:0] addr;
      int          rem;
   } pend_t;
   pend_t pend[$];
   int    lat = 1;

   always begin
      @(negedge clk);
      if (imem_req === 1'b1) pend.push_back('{imem_addr, lat});
      @(posedge clk);
      #1;
      imem_rvalid = 1'b0;
      for (int i = pend.size() - 1; i >= 0; i--) begin
         pend[i].rem = pend[i].rem - 1;
         if (pend[i].rem <= 0) begin
            imem_rvalid = 1'b1;
            imem_rdata  = mem_word(pend[i].addr);
            pend.delete(i);
         end
      end
   end

   // Reference model: queue of (pc, word), the next fetch address, and
   // whether a request is in flight and whether its answer is unwanted.
   typedef struct {
      logic [31:0] pc;
      logic [31:0] instr;
   } ent_t;
   ent_t        mq[$];
   logic [31:0] m_pc = '0;
   bit          m_out = 1'b0;
   bit          m_stale = 1'b0;
   logic [31:0] m_fetched = '0;
   logic [31:0] m_flushed = '0;
   logic [31:0] pop_pc_log[$];
   int          pop_cyc_log[$];

   always @(negedge clk) begin : compare
      bit          e_req, pop, got, good;
      logic [31:0] e_addr;
      int          after;
      cyc++;
      if (rst) begin
         chk1("rst_imem_req", imem_req, 1'b0);
         chk1("rst_if_valid", if_valid, 1'b0);
         chk("rst_imem_addr", imem_addr, 32'h0);
`ifdef IFQ_PERF_EN
         chk("rst_perf_fetched", perf_fetched, 32'h0);
         chk("rst_perf_flushed", perf_flushed, 32'h0);
`endif
         mq.delete();
         m_pc      = 32'h0;
         m_out     = 1'b0;
         m_stale   = 1'b0;
         m_fetched = '0;
         m_flushed = '0;
      end else begin
         chk1("if_valid", if_valid, mq.size() != 0);
         if (mq.size() != 0) begin
            chk("if_pc", if_pc, mq[0].pc);
            chk("if_instr", if_instr, mq[0].instr);
         end
`ifdef IFQ_PERF_EN
         chk("perf_fetched", perf_fetched, m_fetched);
         chk("perf_flushed", perf_flushed, m_flushed);
`endif
         pop = (mq.size() != 0) && id_ready;
         got = m_out && imem_rvalid;
         e_addr = '0;
         if (redirect) begin
            e_req = 1'b0;
            m_flushed = m_flushed + 32'(mq.size()) + ((m_out && !m_stale) ? 32'd1 : 32'd0);
            mq.delete();
            m_pc  = redirect_pc & ~32'h3;
            m_out = m_out && !got;
            if (m_out) m_stale = 1'b1;
         end else begin
            good   = got && !m_stale;
            after  = mq.size() - int'(pop) + int'(good);
            e_req  = (!m_out || good) && (after < DEPTH_I);
            e_addr = good ? m_pc + 32'd4 : m_pc;
            if (pop) begin
               pop_pc_log.push_back(mq[0].pc);
               pop_cyc_log.push_back(cyc);
               void'(mq.pop_front());
            end
            if (good) begin
               mq.push_back('{m_pc, imem_rdata});
               m_pc = m_pc + 32'd4;
               m_fetched = m_fetched + 32'd1;
            end
            if (got) m_out = 1'b0;
            if (e_req) begin
               m_out   = 1'b1;
               m_stale = 1'b0;
            end
         end
         chk1("imem_req", imem_req, e_req);
         if (e_req) chk("imem_addr", imem_addr, e_addr);
      end
   end

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic wait_req(input logic [31:0] addr, input string name);
      bit found = 1'b0;
      for (int i = 0; i < 40 && !found; i++) begin
         @(negedge clk);
         if (imem_req === 1'b1 && imem_addr === addr) found = 1'b1;
      end
      chk1(name, found, 1'b1);
   endtask

   initial begin : watchdog
      #200000;
      $display("FAIL watchdog: simulation did not finish");
      $fatal(1);
   end

   initial begin : stim
      int n8;
      #1 rst = 1'b1;
      id_ready = 1'b1;
      lat = 1;
      repeat (2) tick();

      // 1: streaming with 1-cycle memory, one instruction per cycle
      rst = 1'b0;
      pop_pc_log.delete();
      pop_cyc_log.delete();
      repeat (8) tick();
      chk1("s1_pop_count", pop_pc_log.size() >= 4, 1'b1);
      if (pop_pc_log.size() >= 4) begin
         for (int i = 0; i < 4; i++) chk("s1_pc_order", pop_pc_log[i], 32'(4 * i));
         for (int i = 0; i < 3; i++)
            chk("s1_back_to_back", 32'(pop_cyc_log[i+1] - pop_cyc_log[i]), 32'd1);
      end

      // 2: decode stall fills the queue, then releases in order
      id_ready = 1'b0;
      redirect = 1'b1;
      redirect_pc = 32'h0;
      tick();
      redirect = 1'b0;
      pop_pc_log.delete();
      repeat (10) tick();
      @(negedge clk);
      chk1("s2_valid", if_valid, 1'b1);
      chk("s2_head_pc", if_pc, 32'h0);
      chk("s2_head_instr", if_instr, mem_word(32'h0));
      chk1("s2_no_req_full", imem_req, 1'b0);
      tick();
      id_ready = 1'b1;
      repeat (6) tick();
      chk1("s2_pop_count", pop_pc_log.size() >= 3, 1'b1);
      if (pop_pc_log.size() >= 3) begin
         chk("s2_first", pop_pc_log[0], 32'h0);
         chk("s2_second", pop_pc_log[1], 32'h4);
         chk("s2_third", pop_pc_log[2], 32'h8);
      end

      // 3: redirect while the request to 0x8 is still outstanding
      lat = 3;
      redirect = 1'b1;
      redirect_pc = 32'h0;
      tick();
      redirect = 1'b0;
      wait_req(32'h8, "s3_req_8_seen");
      tick();
      redirect = 1'b1;
      redirect_pc = 32'h100;
      pop_pc_log.delete();
      tick();
      redirect = 1'b0;
      repeat (12) tick();
      chk1("s3_pop_count", pop_pc_log.size() >= 1, 1'b1);
      if (pop_pc_log.size() >= 1) chk("s3_first_after", pop_pc_log[0], 32'h100);
      n8 = 0;
      foreach (pop_pc_log[i]) if (pop_pc_log[i] == 32'h8) n8++;
      chk("s3_stale_0x8", 32'(n8), 32'd0);
`ifdef IFQ_PERF_EN
      chk1("s3_flushed_ge1", perf_flushed >= 32'd1, 1'b1);
`endif

      // 4: redirect coincides with a response and a pop
      lat = 1;
      redirect = 1'b1;
      redirect_pc = 32'h0;
      tick();
      redirect = 1'b0;
      repeat (10) tick();
      redirect = 1'b1;
      redirect_pc = 32'h200;
      @(negedge clk);
      chk1("s4_rvalid_same_cycle", imem_rvalid, 1'b1);
      chk1("s4_pop_same_cycle", if_valid && id_ready, 1'b1);
      tick();
      redirect = 1'b0;
      @(negedge clk);
      chk1("s4_empty_after", if_valid, 1'b0);
      chk1("s4_req_after", imem_req, 1'b1);
      chk("s4_addr_after", imem_addr, 32'h200);

      // 5: unaligned target near the top of the address space wraps
      tick();
      redirect = 1'b1;
      redirect_pc = 32'hFFFF_FFFE;
      pop_pc_log.delete();
      tick();
      redirect = 1'b0;
      @(negedge clk);
      chk1("s5_req0", imem_req, 1'b1);
      chk("s5_addr0", imem_addr, 32'hFFFF_FFFC);
      tick();
      @(negedge clk);
      chk1("s5_req1", imem_req, 1'b1);
      chk("s5_addr1_wrap", imem_addr, 32'h0);
      repeat (4) tick();
      chk1("s5_pop_count", pop_pc_log.size() >= 2, 1'b1);
      if (pop_pc_log.size() >= 2) begin
         chk("s5_pop0", pop_pc_log[0], 32'hFFFF_FFFC);
         chk("s5_pop1", pop_pc_log[1], 32'h0);
      end

      // 6: reset asserted mid-cycle while a request is in flight
      lat = 3;
      id_ready = 1'b0;
      redirect = 1'b1;
      redirect_pc = 32'h40;
      tick();
      redirect = 1'b0;
      wait_req(32'h44, "s6_req_44_seen");
      tick();
      @(negedge clk);
      chk1("s6_pre_valid", if_valid, 1'b1);
      @(posedge clk);
      #3;
      rst = 1'b1;
      #1;
      chk1("s6_imm_valid", if_valid, 1'b0);
      chk1("s6_imm_req", imem_req, 1'b0);
      repeat (5) tick();
      rst = 1'b0;
      id_ready = 1'b1;
      pop_pc_log.delete();
      @(negedge clk);
      chk1("s6_first_req", imem_req, 1'b1);
      chk("s6_first_addr", imem_addr, 32'h0);
      repeat (8) tick();
      chk1("s6_pop_count", pop_pc_log.size() >= 1, 1'b1);
      if (pop_pc_log.size() >= 1) chk("s6_first_pop", pop_pc_log[0], 32'h0);

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
